// File: rtl/adc128s052_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc128s052_pkg
// Description : Shared constants and types for the ADC128S052 controller and
//               its device-side emulator: frame geometry, channel type and
//               emulator FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package adc128s052_pkg;

  // Converter geometry
  localparam int ADC_BITS       = 12;
  localparam int NUM_CH         = 8;
  localparam int FRAME_BITS     = 16;
  localparam int ADDR_FIRST_BIT = 3;
  localparam int LEAD_ZEROS     = 4;
  localparam int CH_BITS        = $clog2(NUM_CH);

  // Bit counter spans 0..FRAME_BITS
  localparam int CNT_BITS = $clog2(FRAME_BITS + 1);

  typedef logic [CH_BITS-1:0]    ch_t;
  typedef logic [ADC_BITS-1:0]   code_t;
  typedef logic [FRAME_BITS-1:0] frame_t;
  typedef logic [CNT_BITS-1:0]   cnt_t;

  // Counter values of interest (bit_cnt holds the number of rising edges seen)
  localparam cnt_t CNT_ZERO  = cnt_t'(0);
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_LAST  = cnt_t'(FRAME_BITS - 1);
  localparam cnt_t CNT_FRAME = cnt_t'(FRAME_BITS);
  // Address bits are captured on rising edges ADDR_FIRST_BIT .. +2, i.e. when
  // the counter still holds the edge number minus one.
  localparam cnt_t CNT_ADDR2 = cnt_t'(ADDR_FIRST_BIT - 1);
  localparam cnt_t CNT_ADDR1 = cnt_t'(ADDR_FIRST_BIT);
  localparam cnt_t CNT_ADDR0 = cnt_t'(ADDR_FIRST_BIT + 1);

  // Emulator FSM encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

  // Serial word for one conversion: leading zeros then the code, MSB first
  function automatic frame_t frame_word(input code_t code);
    return {{LEAD_ZEROS{1'b0}}, code};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc128s052_emu_spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_sync
// Description : N-stage synchronizer for one asynchronous SPI pin, with a
//               delayed copy of the last stage for rise/fall pulse detection.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the pin through the synchronizer chain and keep one delayed copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule
`default_nettype wire

// File: rtl/adc128s052_emu.sv
`default_nettype none
// ============================================================================
// Module      : adc128s052_emu
// Description : Device-side SPI emulation of the ADC128S052. Oversamples
//               CS/SCLK/DIN, captures the next-channel address and shifts
//               12-bit codes from an 8-entry register file out on DOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module adc128s052_emu
  import adc128s052_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] RESET_CODE  = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic        wr_en,
  input  logic [2:0]  wr_ch,
  input  logic [11:0] wr_data,
  output logic        frame_done,
  output logic [2:0]  frame_ch,
  output logic [2:0]  next_ch,
  output logic        abort
);

  // --------------------------------------------------------------------------
  // Pin synchronizers
  // --------------------------------------------------------------------------
  logic cs_level_unused;
  logic cs_rise;
  logic cs_fall;
  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic din_s;
  logic din_rise_unused;
  logic din_fall_unused;

  // cs_n resets to the asserted level: if the controller is mid-frame when
  // reset releases, no fall is seen until cs_n has first been high again.
  spi_edge_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_cs_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (cs_n),
    .level    (cs_level_unused),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // SCLK idles high, so reset to high to avoid a spurious falling edge
  spi_edge_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sclk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sclk),
    .level    (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // din shares the sclk delay, so its level is aligned with sclk_rise
  spi_edge_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_din_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (din),
    .level    (din_s),
    .rise     (din_rise_unused),
    .fall     (din_fall_unused)
  );

  // --------------------------------------------------------------------------
  // Channel register file
  // --------------------------------------------------------------------------
  code_t regfile [NUM_CH];

  // Host writes; the read path below sees the pre-write value in that clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        regfile[i] <= RESET_CODE;
      end
    end else if (wr_en) begin
      regfile[wr_ch] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a cs_n fall opens a frame, a cs_n rise closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: DOUT is only driven onto the bus while a frame is active
  always_comb begin
    dout_oe = 1'b0;
    if (state_q == ST_ACTIVE) begin
      dout_oe = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Shift datapath
  // --------------------------------------------------------------------------
  cnt_t   bit_cnt;
  ch_t    cur_ch;
  ch_t    addr_q;
  frame_t shift_reg;
  frame_t load_word;

  assign load_word = frame_word(regfile[cur_ch]);

  // Bit counting, address capture and DOUT shifting on synchronized edges;
  // cs_n activity is checked first so it wins over a coincident SCLK edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= CNT_ZERO;
      cur_ch     <= '0;
      addr_q     <= '0;
      shift_reg  <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
      frame_ch   <= '0;
      next_ch    <= '0;
      abort      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      abort      <= 1'b0;
      if (state_q == ST_IDLE) begin
        bit_cnt <= CNT_ZERO;
        cur_ch  <= '0;
        dout    <= 1'b0;
      end else if (cs_rise) begin
        // Frame closed early: flag it and drop the partial address
        abort   <= (bit_cnt != CNT_ZERO) && (bit_cnt != CNT_FRAME);
        bit_cnt <= CNT_ZERO;
        cur_ch  <= '0;
        dout    <= 1'b0;
      end else if (sclk_fall) begin
        if (bit_cnt == CNT_ZERO) begin
          dout      <= load_word[FRAME_BITS-1];
          shift_reg <= {load_word[FRAME_BITS-2:0], 1'b0};
        end else begin
          dout      <= shift_reg[FRAME_BITS-1];
          shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
        end
      end else if (sclk_rise) begin
        if (bit_cnt == CNT_LAST) begin
          // Rising edge 16: report the frame and switch to the new channel
          frame_done <= 1'b1;
          frame_ch   <= cur_ch;
          next_ch    <= addr_q;
          cur_ch     <= addr_q;
          bit_cnt    <= CNT_ZERO;
        end else begin
          bit_cnt <= bit_cnt + CNT_ONE;
          case (bit_cnt)
            CNT_ADDR2: addr_q[CH_BITS-1] <= din_s;
            CNT_ADDR1: addr_q[CH_BITS-2] <= din_s;
            CNT_ADDR0: addr_q[CH_BITS-3] <= din_s;
            default:   ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc128s052_emu.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc128s052_emu
// Description : Self-checking bench for adc128s052_emu. Drives SPI frames at
//               clk/8 and checks DOUT bits and frame reports via a queue of
//               expected frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc128s052_emu;

  localparam logic [11:0] TB_RESET_CODE = 12'h3C5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic        sclk;
  logic        din;
  logic        dout;
  logic        dout_oe;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;
  logic        frame_done;
  logic [2:0]  frame_ch;
  logic [2:0]  next_ch;
  logic        abort;

  adc128s052_emu #(
    .SYNC_STAGES (2),
    .RESET_CODE  (TB_RESET_CODE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .din        (din),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_ch   (frame_ch),
    .next_ch    (next_ch),
    .abort      (abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    logic [2:0]  fch;
    logic [2:0]  nch;
  } exp_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] bits;
    logic [2:0]  fch;
    logic [2:0]  nch;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[8];
  int          checks      = 0;
  int          failures    = 0;
  int          frames_seen = 0;
  int          aborts_seen = 0;
  int          pushes      = 0;
  logic [15:0] cap_bits;
  logic [15:0] cap_early;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] bits, input logic [2:0] fch, input logic [2:0] nch);
    exp_t e;
    e.bits = bits;
    e.fch  = fch;
    e.nch  = nch;
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic reg_write(input logic [2:0] ch, input logic [11:0] data);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_data = data;
    idle(1);
    wr_en   = 1'b0;
  endtask

  // One SPI frame (or its first n_rise bits) at 8 clk per SCLK period.
  // Optionally writes channel 0 in the clk where falling edge 1 loads.
  task automatic run_frame(input logic [2:0] a, input int n_rise, input logic do_wr,
                           input logic [11:0] wdata);
    logic [15:0] bits;
    logic [15:0] early;
    bits  = '0;
    early = '0;
    for (int b = 0; b < n_rise; b++) begin
      sclk = 1'b0;
      din  = (b == 2) ? a[2] : (b == 3) ? a[1] : (b == 4) ? a[0] : 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        #1;
        if (c == 1) early[15-b] = dout;
        if (c == 2) bits[15-b] = dout;
        if (do_wr && b == 0) begin
          if (c == 1) begin
            wr_en   = 1'b1;
            wr_ch   = 3'd0;
            wr_data = wdata;
          end else if (c == 2) begin
            wr_en = 1'b0;
          end
        end
      end
      if (b == 15) begin
        cap_bits  = bits;
        cap_early = early;
      end
      sclk = 1'b1;
      idle(4);
    end
  endtask

  // Scoreboard: each frame report is matched against the oldest expectation
  always @(negedge clk) begin
    if (frame_done) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_bits", {16'h0, cap_bits}, {16'h0, e.bits});
        chk("frame_ch", {29'h0, frame_ch}, {29'h0, e.fch});
        chk("next_ch", {29'h0, next_ch}, {29'h0, e.nch});
      end
    end
    if (abort) aborts_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int a0;

    for (int k = 1; k <= 8; k++) begin
      vecs[k-1].addr = 3'(k % 8);
      vecs[k-1].bits = {4'b0000, 12'h100 + 12'((k - 1) % 8)};
      vecs[k-1].fch  = 3'((k - 1) % 8);
      vecs[k-1].nch  = 3'(k % 8);
    end

    rst_n   = 1'b0;
    cs_n    = 1'b1;
    sclk    = 1'b1;
    din     = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = 3'd0;
    wr_data = 12'h000;
    idle(4);

    // Reset state
    chk("rst_dout", {31'h0, dout}, 32'd0);
    chk("rst_dout_oe", {31'h0, dout_oe}, 32'd0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'd0);
    chk("rst_abort", {31'h0, abort}, 32'd0);
    chk("rst_frame_ch", {29'h0, frame_ch}, 32'd0);
    chk("rst_next_ch", {29'h0, next_ch}, 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Single frame from channel 0
    reg_write(3'd0, 12'hABC);
    cs_n = 1'b0;
    idle(4);
    chk("active_dout_oe", {31'h0, dout_oe}, 32'd1);
    push_exp(16'h0ABC, 3'd0, 3'd0);
    run_frame(3'd0, 16, 1'b0, 12'h000);
    // Two clk after each pin fall DOUT still shows the previous bit
    chk("dout_latency_early", {16'h0, cap_early}, {16'h0, 16'h055E});
    cs_n = 1'b1;
    idle(8);
    chk("idle_dout_oe", {31'h0, dout_oe}, 32'd0);
    chk("idle_dout", {31'h0, dout}, 32'd0);

    // Eight back-to-back frames walking the channel address
    for (int i = 0; i < 8; i++) reg_write(3'(i), 12'h100 + 12'(i));
    cs_n = 1'b0;
    idle(4);
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].bits, vecs[i].fch, vecs[i].nch);
      run_frame(vecs[i].addr, 16, 1'b0, 12'h000);
    end

    // Write to channel 0 in the same clk as its load
    push_exp(16'h0100, 3'd0, 3'd0);
    run_frame(3'd0, 16, 1'b1, 12'h5A5);
    push_exp(16'h05A5, 3'd0, 3'd0);
    run_frame(3'd0, 16, 1'b0, 12'h000);
    cs_n = 1'b1;
    idle(8);

    // Early cs_n rise after 9 rising edges
    cs_n = 1'b0;
    idle(4);
    f0 = frames_seen;
    a0 = aborts_seen;
    run_frame(3'd3, 9, 1'b0, 12'h000);
    cs_n = 1'b1;
    idle(8);
    chk("abort_count", 32'(aborts_seen - a0), 32'd1);
    chk("abort_no_frame", 32'(frames_seen - f0), 32'd0);
    chk("abort_dout_oe", {31'h0, dout_oe}, 32'd0);
    cs_n = 1'b0;
    idle(4);
    push_exp(16'h05A5, 3'd0, 3'd5);
    run_frame(3'd5, 16, 1'b0, 12'h000);

    // Reset in the middle of the following frame
    run_frame(3'd2, 7, 1'b0, 12'h000);
    rst_n = 1'b0;
    idle(2);
    chk("midrst_dout", {31'h0, dout}, 32'd0);
    chk("midrst_dout_oe", {31'h0, dout_oe}, 32'd0);
    chk("midrst_frame_ch", {29'h0, frame_ch}, 32'd0);
    chk("midrst_next_ch", {29'h0, next_ch}, 32'd0);
    chk("midrst_frame_done", {31'h0, frame_done}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    // cs_n stays low: this frame must be ignored
    f0 = frames_seen;
    run_frame(3'd1, 16, 1'b0, 12'h000);
    chk("postrst_ignored_frame", 32'(frames_seen - f0), 32'd0);
    chk("postrst_dout_oe", {31'h0, dout_oe}, 32'd0);
    cs_n = 1'b1;
    idle(8);
    cs_n = 1'b0;
    idle(4);
    push_exp({4'b0000, TB_RESET_CODE}, 3'd0, 3'd0);
    run_frame(3'd0, 16, 1'b0, 12'h000);
    cs_n = 1'b1;
    idle(10);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_total", 32'(frames_seen), 32'(pushes));
    chk("abort_total", 32'(aborts_seen), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
